fetch_unit: RTL

Parametrised instruction-fetch stage for the riscv64 core. It owns the PC and issues sequential requests on a valid/ready instruction-memory port. In-order responses land in a BUF_DEPTH-entry buffer that feeds decode through a valid/ready handshake. A single-cycle redirect flushes the buffer, retargets the PC and discards responses still in flight.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues sequential imem requests,
// buffers in-order responses and hands them to decode on a valid/ready port.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   redirect_valid, redirect_pc       flush buffer and retarget the PC
//   imem_req_valid/ready/addr         request channel to instruction memory
//   imem_resp_valid/data/err          in-order response channel
//   out_valid/ready/instr/pc/fault    instruction handoff to decode
module fetch_unit #(
    parameter int          XLEN      = 64,
    parameter int          ILEN      = 32,
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [XLEN-1:0] PC_RST  = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN   = ~(XLEN'(3));
    localparam logic [PW+1:0]   DEPTH   = (PW+2)'(BUF_DEPTH);

    typedef logic [PW:0] ptr_t;

    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      ent_pc    [BUF_DEPTH];
    logic [ILEN-1:0]      ent_instr [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] ent_fault;
    logic [BUF_DEPTH-1:0] ent_filled;

    ptr_t alloc_ptr;
    ptr_t fill_ptr;
    ptr_t head_ptr;
    ptr_t drop_cnt;

    ptr_t          allocated;
    ptr_t          unfilled;
    logic [PW+1:0] credit;
    logic [PW-1:0] alloc_idx;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] head_idx;
    logic          req_fire;
    logic          pop;

    assign allocated = alloc_ptr - head_ptr;
    assign unfilled  = alloc_ptr - fill_ptr;
    // Squashed responses still in flight hold credit until they return.
    assign credit    = {1'b0, allocated} + {1'b0, drop_cnt};

    assign alloc_idx = alloc_ptr[PW-1:0];
    assign fill_idx  = fill_ptr[PW-1:0];
    assign head_idx  = head_ptr[PW-1:0];

    assign imem_req_valid = rst_n && !redirect_valid && (credit < DEPTH);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = ent_filled[head_idx] && !redirect_valid;
    assign out_pc    = ent_pc[head_idx];
    assign out_instr = ent_instr[head_idx];
    assign out_fault = ent_fault[head_idx];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= PC_RST;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            drop_cnt   <= '0;
            ent_fault  <= '0;
            ent_filled <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                ent_pc[i]    <= '0;
                ent_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc         <= redirect_pc & ALIGN;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            ent_filled <= '0;
            // Every unfilled entry becomes a response to squash; any
            // response arriving now is consumed against the total.
            drop_cnt   <= drop_cnt + unfilled - ptr_t'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                ent_pc[alloc_idx]     <= pc;
                ent_filled[alloc_idx] <= 1'b0;
                alloc_ptr             <= alloc_ptr + ptr_t'(1);
                pc                    <= pc + PC_STEP;
            end
            if (imem_resp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - ptr_t'(1);
                end else begin
                    ent_instr[fill_idx]  <= imem_resp_err ? '0
                                                          : imem_resp_data;
                    ent_fault[fill_idx]  <= imem_resp_err;
                    ent_filled[fill_idx] <= 1'b1;
                    fill_ptr             <= fill_ptr + ptr_t'(1);
                end
            end
            if (pop) begin
                ent_filled[head_idx] <= 1'b0;
                head_ptr             <= head_ptr + ptr_t'(1);
            end
        end
    end

endmodule
